// File: rtl/nn_layer_sequencer.sv
// Control FSM for the 4-input neuron layer datapath. It loads 4 input words
// per sample, runs NUM_LAYERS compute/write-back passes through the shared
// neuron bank, and flags result words as they shift out of the shift register.
module nn_layer_sequencer #(
    parameter int NUM_LAYERS     = 3,
    parameter int NEURON_LATENCY = 2,
    parameter int LAYER_W        = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               data_valid,
    output logic               data_ready,
    input  logic               flush,
    output logic [1:0]         selector,
    output logic               neuron_en,
    output logic [LAYER_W-1:0] layer_idx,
    output logic               out_valid,
    output logic               busy,
    output logic               done
);

    localparam int LAT_W = (NEURON_LATENCY > 1) ? $clog2(NEURON_LATENCY) : 1;
    localparam logic [LAT_W-1:0]   LAT_LAST   = LAT_W'(NEURON_LATENCY - 1);
    localparam logic [LAYER_W-1:0] LAYER_LAST = LAYER_W'(NUM_LAYERS - 1);

    localparam logic [1:0] SEL_SHIFT = 2'b00;
    localparam logic [1:0] SEL_HOLD  = 2'b01;
    localparam logic [1:0] SEL_LOAD  = 2'b10;

    typedef enum logic [1:0] {LOAD, COMPUTE, WRITEBACK, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [1:0]         in_cnt_q, in_cnt_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [LAYER_W-1:0] layer_q, layer_d;
    logic               pend_q, pend_d;
    logic [1:0]         out_cnt_q, out_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic               done_q, done_d;
    logic               wb_last;

    assign layer_idx = layer_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;

    // Next-state, counters and combinational output decode
    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        layer_d     = layer_q;
        pend_d      = pend_q;
        out_cnt_d   = out_cnt_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        wb_last     = 1'b0;
        selector    = SEL_HOLD;
        data_ready  = 1'b0;
        neuron_en   = 1'b0;
        busy        = 1'b0;

        unique case (state_q)
            LOAD: begin
                data_ready = 1'b1;
                busy       = (in_cnt_q != 2'd0);
                if (data_valid) begin
                    // A real word always wins over a flush request
                    selector = SEL_SHIFT;
                    in_cnt_d = in_cnt_q + 2'd1;
                    if (in_cnt_q == 2'd3) begin
                        lat_cnt_d = '0;
                        state_d   = COMPUTE;
                    end
                end else if (flush && in_cnt_q == 2'd0 && pend_q) begin
                    state_d = DRAIN;
                end
            end
            COMPUTE: begin
                neuron_en = 1'b1;
                busy      = 1'b1;
                if (lat_cnt_q == LAT_LAST) state_d = WRITEBACK;
                else                       lat_cnt_d = lat_cnt_q + 1'b1;
            end
            WRITEBACK: begin
                selector = SEL_LOAD;
                busy     = 1'b1;
                if (layer_q == LAYER_LAST) begin
                    wb_last = 1'b1;
                    layer_d = '0;
                    done_d  = 1'b1;
                    state_d = LOAD;
                end else begin
                    layer_d   = layer_q + 1'b1;
                    lat_cnt_d = '0;
                    state_d   = COMPUTE;
                end
            end
            DRAIN: begin
                // data_in is don't-care here; only the results matter
                selector = SEL_SHIFT;
                if (out_cnt_q == 2'd3) state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase

        // Every shift while a result is pending pushes one result word out
        if (selector == SEL_SHIFT && pend_q) begin
            out_valid_d = 1'b1;
            out_cnt_d   = out_cnt_q + 2'd1;
            if (out_cnt_q == 2'd3) pend_d = 1'b0;
        end

        // A freshly completed sample overrides any clear above
        if (wb_last) begin
            pend_d    = 1'b1;
            out_cnt_d = 2'd0;
        end

        // Keep the datapath quiet while held in reset
        if (!rstn) begin
            selector   = SEL_HOLD;
            data_ready = 1'b0;
            neuron_en  = 1'b0;
            busy       = 1'b0;
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= LOAD;
            in_cnt_q    <= 2'd0;
            lat_cnt_q   <= '0;
            layer_q     <= '0;
            pend_q      <= 1'b0;
            out_cnt_q   <= 2'd0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            layer_q     <= layer_d;
            pend_q      <= pend_d;
            out_cnt_q   <= out_cnt_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer with default parameters.
module tb_nn_layer_sequencer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       flush = 1'b0;
    logic [1:0] selector;
    logic       neuron_en;
    logic [1:0] layer_idx;
    logic       out_valid;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    nn_layer_sequencer #(.NUM_LAYERS(3), .NEURON_LATENCY(2), .LAYER_W(2)) dut (
        .clk(clk), .rstn(rstn), .data_valid(data_valid), .data_ready(data_ready),
        .flush(flush), .selector(selector), .neuron_en(neuron_en),
        .layer_idx(layer_idx), .out_valid(out_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle outputs for cycles t+1..t+10 after the 4th word
    logic [1:0] exp_sel [10] = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01};
    logic       exp_en  [10] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 0};
    logic [1:0] exp_lay [10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0};
    logic       exp_dn  [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    logic       exp_by  [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};

    // Load one sample (optionally gapped), then check ncyc cycles of sequencing.
    // pend says whether earlier results shift out during this load.
    task automatic run_sample(input bit gap, input bit pend, input bit fl, input int ncyc);
        int  n = 0;
        int  c = 0;
        bit  prev_x = 0;
        bit  dv;
        while (n < 4) begin
            dv = gap ? ((c % 2) == 0) : 1'b1;
            data_valid = dv;
            flush = fl;
            #1;
            chk("load_sel", selector, dv ? 2'b00 : 2'b01);
            chk("load_rdy", data_ready, 1'b1);
            chk("load_busy", busy, (n != 0));
            chk("load_ov", out_valid, prev_x && pend);
            chk("load_en", neuron_en, 1'b0);
            prev_x = dv;
            if (dv) n++;
            c++;
            tick();
        end
        data_valid = 1'b0;
        flush = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            #1;
            chk("seq_sel", selector, exp_sel[k]);
            chk("seq_en", neuron_en, exp_en[k]);
            chk("seq_layer", layer_idx, exp_lay[k]);
            chk("seq_done", done, exp_dn[k]);
            chk("seq_busy", busy, exp_by[k]);
            chk("seq_rdy", data_ready, (k == 9));
            chk("seq_ov", out_valid, (k == 0) && pend);
            if (k < ncyc - 1) tick();
        end
    endtask

    initial begin
        // Reset held with data_valid high
        rstn = 1'b0;
        data_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("rst_sel", selector, 2'b01);
            chk("rst_rdy", data_ready, 1'b0);
        end
        rstn = 1'b1;
        data_valid = 1'b0;
        tick();
        chk("rel_rdy", data_ready, 1'b1);
        chk("rel_layer", layer_idx, 2'd0);
        chk("rel_ov", out_valid, 1'b0);
        chk("rel_done", done, 1'b0);
        chk("rel_busy", busy, 1'b0);

        // Sample 1: back-to-back, nothing pending
        run_sample(0, 0, 0, 10);
        // Sample 2: gapped, shifts sample 1 results out
        run_sample(1, 1, 0, 10);

        // Flush from the done cycle of sample 2
        flush = 1'b1;
        #1;
        chk("fl_sel0", selector, 2'b01);
        chk("fl_rdy0", data_ready, 1'b1);
        tick();
        flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("drain_sel", selector, 2'b00);
            chk("drain_rdy", data_ready, 1'b0);
            chk("drain_ov", out_valid, (k != 0));
            tick();
        end
        #1;
        chk("drain_end_rdy", data_ready, 1'b1);
        chk("drain_end_sel", selector, 2'b01);
        chk("drain_end_ov", out_valid, 1'b1);
        // Second flush: nothing pending, must be ignored
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("fl2_sel", selector, 2'b01);
            chk("fl2_rdy", data_ready, 1'b1);
            chk("fl2_ov", out_valid, 1'b0);
            tick();
        end

        // Sample 3 with nothing pending; sample 4 with flush held high (data wins)
        run_sample(0, 0, 0, 10);
        run_sample(0, 1, 1, 10);

        // Sample 5: reset during layer-1 COMPUTE
        run_sample(0, 1, 0, 4);
        rstn = 1'b0;
        #1;
        chk("mid_rst_rdy", data_ready, 1'b0);
        chk("mid_rst_en", neuron_en, 1'b0);
        tick();
        rstn = 1'b1;
        #1;
        chk("mid_layer", layer_idx, 2'd0);
        chk("mid_rdy", data_ready, 1'b1);
        chk("mid_busy", busy, 1'b0);
        chk("mid_ov", out_valid, 1'b0);
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("mid_nodone", done, 1'b0);
            chk("mid_noen", neuron_en, 1'b0);
        end

        // Sample 6, then reset while results pending, then flush must be ignored
        run_sample(0, 0, 0, 10);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("rstp_sel", selector, 2'b01);
        chk("rstp_rdy", data_ready, 1'b1);
        chk("rstp_ov", out_valid, 1'b0);
        tick();
        chk("rstp_ov2", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
